// File: rtl/mod_cntr8_cla_if.sv
// Command/status bundle for the 8-bit modulo counter.
//   master : drives load/inc/dec/d_in/limit, observes d_out/tc/o_state/cla_co
//   slave  : the counter itself
//   load    load command (highest priority)
//   inc/dec count-up / count-down requests
//   d_in    load data
//   limit   modulus limit, sampled only while load=1
//   d_out   registered count
//   tc      registered terminal-count pulse
//   o_state current FSM state encoding
//   cla_co  carry out of the upper look-ahead nibble (observation probe only)
interface mod_cntr8_cla_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] d_out;
    logic             tc;
    logic [2:0]       o_state;
    logic             cla_co;

    modport master (
        output load, inc, dec, d_in, limit,
        input  d_out, tc, o_state, cla_co
    );

    modport slave (
        input  load, inc, dec, d_in, limit,
        output d_out, tc, o_state, cla_co
    );
endinterface

// File: rtl/mod_cntr8_cla.sv
// 8-bit loadable modulo up/down counter. The next count is formed by an
// 8-bit carry look-ahead adder built from two 4-bit look-ahead carry blocks
// with the registered count fed back as operand A.
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    command/status bundle (slave side), see mod_cntr8_cla_if

// 4-bit look-ahead carry block: produces the internal carries c1..c3 and
// the block carry out directly from generate/propagate terms.
module mod_cntr8_cla_lcu4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] c,
    output logic       co
);
    logic [3:0] p;
    logic [3:0] g;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);
endmodule

module mod_cntr8_cla #(
    parameter logic [7:0] RST_LIMIT = 8'hFF,
    parameter int         WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mod_cntr8_cla_if.slave        bus
);
    localparam int NIBS = WIDTH / 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_INC  = 3'b010,
        S_DEC  = 3'b011,
        S_HOLD = 3'b100
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lim_r;
    logic             tc_r;

    // ------------------------------------------------------------------
    // Next-state decode. Both-requests and no-request collapse to HOLD,
    // except that an idle counter stays idle until it is first commanded.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (bus.load)
            state_nxt = S_LOAD;
        else if (bus.inc && !bus.dec)
            state_nxt = S_INC;
        else if (bus.dec && !bus.inc)
            state_nxt = S_DEC;
        else if (state != S_IDLE)
            state_nxt = S_HOLD;
        else
            state_nxt = S_IDLE;
    end

    // ------------------------------------------------------------------
    // CLA: A = current count; B = +1 for counting up, all-ones (-1) for
    // counting down. Low nibble has ci=0; upper nibble chains off it.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]          add_b;
    logic [NIBS:0]             nib_ci;
    logic [NIBS-1:0][3:0]      nib_c;
    logic [WIDTH-1:0]          carry;
    logic [WIDTH-1:0]          sum;

    assign add_b     = (state_nxt == S_DEC) ? {WIDTH{1'b1}} : WIDTH'(1);
    assign nib_ci[0] = 1'b0;

    genvar n;
    generate
        for (n = 0; n < NIBS; n++) begin : g_nib
            mod_cntr8_cla_lcu4 u_lcu (
                .a  (cnt[4*n +: 4]),
                .b  (add_b[4*n +: 4]),
                .ci (nib_ci[n]),
                .c  (nib_c[n]),
                .co (nib_ci[n+1])
            );
        end
    endgenerate

    assign carry = nib_c;
    assign sum   = cnt ^ add_b ^ carry;

    // Clamp a loaded value against the incoming limit, not the old lim_r.
    logic [WIDTH-1:0] load_val;
    assign load_val = (bus.d_in > bus.limit) ? bus.limit : bus.d_in;

    // ------------------------------------------------------------------
    // State and datapath registers. The update is keyed off the next
    // state so a command shows up on d_out one cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            tc_r  <= 1'b0;
            lim_r <= RST_LIMIT;
        end else begin
            state <= state_nxt;
            tc_r  <= 1'b0;
            case (state_nxt)
                S_LOAD: begin
                    lim_r <= bus.limit;
                    cnt   <= load_val;
                end
                S_INC: begin
                    // >= rather than == keeps the count in range even if
                    // it were ever found above the limit.
                    if (cnt >= lim_r) begin
                        cnt  <= '0;
                        tc_r <= 1'b1;
                    end else begin
                        cnt  <= sum;
                    end
                end
                S_DEC: begin
                    if (cnt == '0) begin
                        cnt  <= lim_r;
                        tc_r <= 1'b1;
                    end else begin
                        cnt  <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.d_out   = cnt;
    assign bus.tc      = tc_r;
    assign bus.o_state = state;
    assign bus.cla_co  = nib_ci[NIBS];
endmodule

// File: tb/tb_mod_cntr8_cla.sv
module tb_mod_cntr8_cla;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mod_cntr8_cla_if bus ();

    mod_cntr8_cla #(.RST_LIMIT(8'hFF), .WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic up, input logic dn,
                         input logic [7:0] din, input logic [7:0] lim);
        bus.load  = ld;
        bus.inc   = up;
        bus.dec   = dn;
        bus.d_in  = din;
        bus.limit = lim;
    endtask

    task automatic expect3(input string tag, input logic [7:0] q,
                           input logic t, input logic [2:0] st);
        chk({tag, ".d_out"},   bus.d_out, q);
        chk({tag, ".tc"},      {7'b0, bus.tc}, {7'b0, t});
        chk({tag, ".o_state"}, {5'b0, bus.o_state}, {5'b0, st});
    endtask

    // reference model for the random run
    logic [7:0] m_cnt, m_lim;
    logic       m_tc;
    logic [2:0] m_st;

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        #1;

        // 1: reset overrides inc; idle stays idle; first increment
        cyc(); cyc();
        expect3("rst", 8'h00, 1'b0, 3'b000);
        reset = 1'b0; bus.inc = 1'b0;
        cyc();
        expect3("idle", 8'h00, 1'b0, 3'b000);
        bus.inc = 1'b1;
        cyc();
        expect3("inc1", 8'h01, 1'b0, 3'b010);

        // 2: load 0E/limit 0F then count up across the wrap
        drive(1'b1, 1'b0, 1'b0, 8'h0E, 8'h0F); cyc();
        expect3("ld0e", 8'h0E, 1'b0, 3'b001);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h0F);
        cyc(); expect3("up0f", 8'h0F, 1'b0, 3'b010);
        cyc(); expect3("wrap", 8'h00, 1'b1, 3'b010);
        cyc(); expect3("up01", 8'h01, 1'b0, 3'b010);

        // 3: down-count wrap from zero to the limit
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h05); cyc();
        expect3("ld00", 8'h00, 1'b0, 3'b001);
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h05);
        cyc(); expect3("dnwrap", 8'h05, 1'b1, 3'b011);
        cyc(); expect3("dn04", 8'h04, 1'b0, 3'b011);

        // 4: carry/borrow across the nibble boundary
        drive(1'b1, 1'b0, 1'b0, 8'h0F, 8'hFF); cyc();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF); cyc();
        expect3("c0f10", 8'h10, 1'b0, 3'b010);
        drive(1'b1, 1'b0, 1'b0, 8'h10, 8'hFF); cyc();
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF); cyc();
        expect3("b100f", 8'h0F, 1'b0, 3'b011);
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF); cyc();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF); cyc();
        expect3("ffwrap", 8'h00, 1'b1, 3'b010);

        // 5: clamp, both-requests hold, load beats inc, limit ignored w/o load
        drive(1'b1, 1'b0, 1'b0, 8'hC8, 8'h64); cyc();
        expect3("clamp", 8'h64, 1'b0, 3'b001);
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h64); cyc();
        expect3("both", 8'h64, 1'b0, 3'b100);
        drive(1'b1, 1'b1, 1'b0, 8'h07, 8'h64); cyc();
        expect3("ldwins", 8'h07, 1'b0, 3'b001);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h02); cyc();
        cyc();
        expect3("limign", 8'h09, 1'b0, 3'b010);

        // limit 0: every count request wraps
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00); cyc();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        cyc(); expect3("l0i1", 8'h00, 1'b1, 3'b010);
        cyc(); expect3("l0i2", 8'h00, 1'b1, 3'b010);
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cyc(); expect3("l0d", 8'h00, 1'b1, 3'b011);

        // 6: reset in the middle of counting restores limit FF
        drive(1'b1, 1'b0, 1'b0, 8'h38, 8'hFF); cyc();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF); cyc(); cyc();
        chk("at3a", bus.d_out, 8'h3A);
        reset = 1'b1; cyc();
        expect3("midrst", 8'h00, 1'b0, 3'b000);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h12); cyc();
        expect3("rstlim", 8'hFF, 1'b1, 3'b011);

        // random run against the model
        m_cnt = 8'hFF; m_lim = 8'hFF; m_tc = 1'b1; m_st = 3'b011;
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            bus.load  = ($urandom_range(0, 7) == 0);
            bus.inc   = $urandom_range(0, 1);
            bus.dec   = $urandom_range(0, 1);
            bus.d_in  = 8'($urandom);
            bus.limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if (reset) begin
                m_cnt = 8'h00; m_tc = 1'b0; m_lim = 8'hFF; m_st = 3'b000;
            end else if (bus.load) begin
                m_lim = bus.limit;
                m_cnt = (bus.d_in > bus.limit) ? bus.limit : bus.d_in;
                m_tc = 1'b0; m_st = 3'b001;
            end else if (bus.inc && !bus.dec) begin
                m_st = 3'b010;
                m_tc = (m_cnt == m_lim);
                m_cnt = m_tc ? 8'h00 : m_cnt + 8'h01;
            end else if (bus.dec && !bus.inc) begin
                m_st = 3'b011;
                m_tc = (m_cnt == 8'h00);
                m_cnt = m_tc ? m_lim : m_cnt - 8'h01;
            end else begin
                m_tc = 1'b0;
                m_st = (m_st == 3'b000) ? 3'b000 : 3'b100;
            end
            cyc();
            expect3("rnd", m_cnt, m_tc, m_st);
            n_tests++;
            assert (bus.d_out <= m_lim) else begin
                n_fail++;
                $error("FAIL rnd.range: got %0h, expected <= %0h", bus.d_out, m_lim);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mod_cntr8_cla.md
Name: mod_cntr8_cla

Overview:
- 8-bit loadable modulo up/down counter; the next count value is produced by an 8-bit carry look-ahead adder built from two 4-bit look-ahead carry blocks.
- Consumes the block carries c1/c2/c3/co to form the sum bits, and feeds its registered count back as the adder's A operand.
- Sits in the counter datapath and drives the shared count bus and the terminal-count event line.

Parameters:
- RST_LIMIT, 8'hFF, modulus limit loaded at reset (count range 0..limit).
- WIDTH, 8, count width. Fixed at 8; only the 8 value is supported and verified.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  load command; highest priority.
- inc  input  1  count-up request.
- dec  input  1  count-down request.
- d_in  input  8  load data.
- limit  input  8  modulus limit; sampled only when load=1.
- d_out  output  8  registered count value.
- tc  output  1  registered terminal-count pulse, one cycle wide.
- o_state  output  3  current FSM state encoding.

Behaviour:
- All state updates occur on rising clk; no asynchronous paths.
- Reset (reset=1 at an edge), which overrides all commands, including a reset arriving mid-count:
  - d_out=8'h00, tc=0, lim_r=RST_LIMIT, state=IDLE.
- FSM state encodings:
  - IDLE=3'b000, LOAD=3'b001, INC=3'b010, DEC=3'b011, HOLD=3'b100.
  - o_state = current state register.
- Next-state decode, evaluated every cycle, in priority order:
  - load=1 -> LOAD.
  - Otherwise inc=1 and dec=0 -> INC.
  - Otherwise dec=1 and inc=0 -> DEC.
  - Otherwise (both 0, or both 1) -> HOLD if the current state is not IDLE; IDLE stays IDLE.
- Datapath: the register update is decided by the next state, so latency is 1 cycle from command to d_out.
  - LOAD: lim_r <= limit; d_out <= min(d_in, limit), comparing against the new limit, not the old lim_r.
  - INC:
    - If d_out == lim_r: d_out <= 8'h00 and tc <= 1.
    - Else d_out <= d_out + 1, computed by the CLA with b=8'h01, ci=0.
  - DEC:
    - If d_out == 8'h00: d_out <= lim_r and tc <= 1.
    - Else d_out <= d_out + 8'hFF, computed by the CLA with b=8'hFF, ci=0; the carry-out is discarded.
  - HOLD/IDLE: d_out unchanged.
  - tc is 0 in every cycle that did not wrap; it is never high for two consecutive cycles unless wraps occur back-to-back (e.g. lim_r=0 while counting).
- Adder structure:
  - Low nibble: look-ahead block with ci=0.
  - High nibble: look-ahead block with ci = low-nibble co.
  - sum[i] = a[i] ^ b[i] ^ c[i], with c[0]=ci.
  - The final carry out of the high nibble is unused except for the verification probe.
- Boundary conditions:
  - lim_r=0 with INC or DEC held: d_out stays 0 and tc=1 every cycle.
  - load with d_in > limit: d_out clamps to limit, and tc=0.
  - load together with inc or dec: the load wins and the count request is ignored.
  - inc and dec both high: treated as HOLD.
  - Changing limit while load=0 has no effect.
  - After an out-of-order wrap the count stays within 0..lim_r at all times. This invariant must hold.

Test Plan:
1. reset=1 for 2 cycles with inc=1 -> d_out=00, tc=0, o_state=000. After reset release with inc=1, d_out=01 one cycle later, o_state=010.
2. load=1, d_in=8'h0E, limit=8'h0F; then inc for 3 cycles -> d_out sequence 0E, 0F, 00, 01. tc=1 only in the cycle d_out=00.
3. load d_in=00, limit=8'h05; dec for 2 cycles -> d_out 05 with tc=1, then 04 with tc=0.
4. CLA carry ripple across nibbles: load d_in=8'h0F, limit=FF, inc -> d_out=10. load d_in=8'h10, dec -> d_out=0F. load d_in=FF, inc -> 00 with tc=1.
5. load d_in=8'hC8, limit=8'h64 -> d_out=64. Then inc=dec=1 -> d_out stays 64, o_state=100. Then load=1 with inc=1, d_in=07 -> d_out=07, o_state=001.
6. While counting up at d_out=3A, assert reset for 1 cycle -> d_out=00, lim_r=FF. Random 2000-cycle run checked against a reference model: d_out <= lim_r always, and tc matches the model's wrap events.
